// File: rtl/addsub_rr_scheduler_if.sv
// Request/response bundle for addsub_rr_scheduler.
// The master side is the requesters plus the result consumer; the slave side is the scheduler.
interface addsub_rr_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int AW      = 4,
    parameter int BW      = 8,
    parameter int OW      = 9,
    parameter int IDW     = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*AW-1:0] req_a;
    logic [NUM_REQ*BW-1:0] req_b;
    logic [NUM_REQ-1:0]    req_sub;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [OW-1:0]         rsp_data;
    logic [IDW-1:0]        rsp_id;
    logic                  rsp_sat;

    modport master (
        output req_valid, req_a, req_b, req_sub, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_sat
    );

    modport slave (
        input  req_valid, req_a, req_b, req_sub, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id, rsp_sat
    );
endinterface

// File: rtl/addsub_rr_scheduler.sv
// Round-robin shared signed add/subtract unit with a 2-stage backpressured pipeline.
// Define ADDSUB_RR_SAT_EN to clamp results to OW bits and report rsp_sat; otherwise results wrap.
module addsub_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int AW      = 4,
    parameter int BW      = 8,
    parameter int OW      = 9,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_b,
    addsub_rr_scheduler_if.slave  bus
);
    localparam int RW = ((AW > BW + 1) ? AW : BW + 1) + 1;

    logic [AW-1:0] a_arr [NUM_REQ];
    logic [BW-1:0] b_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign a_arr[gi] = bus.req_a[gi*AW +: AW];
            assign b_arr[gi] = bus.req_b[gi*BW +: BW];
        end
    endgenerate

    logic [IDW-1:0]     rr_ptr_q;
    logic               s1_valid_q;
    logic [AW-1:0]      s1_a_q;
    logic [BW-1:0]      s1_b_q;
    logic               s1_sub_q;
    logic [IDW-1:0]     s1_id_q;
    logic               s2_valid_q;
    logic [OW-1:0]      s2_data_q;
    logic [IDW-1:0]     s2_id_q;

    logic               adv1;
    logic               adv2;
    logic [NUM_REQ-1:0] grant;
    logic               grant_any;
    logic [IDW-1:0]     grant_id;

    assign adv2 = bus.rsp_ready | ~s2_valid_q;
    assign adv1 = adv2 | ~s1_valid_q;

    // Search starts at rr_ptr; no grants are issued while reset is held.
    always_comb begin
        logic [IDW:0]   sum;
        logic [IDW-1:0] idx;
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        sum       = '0;
        idx       = '0;
        if (rst_b && adv1) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                sum = {1'b0, rr_ptr_q} + (IDW+1)'(k);
                if (sum >= (IDW+1)'(NUM_REQ)) begin
                    sum = sum - (IDW+1)'(NUM_REQ);
                end
                idx = sum[IDW-1:0];
                if (!grant_any && bus.req_valid[idx]) begin
                    grant[idx] = 1'b1;
                    grant_id   = idx;
                    grant_any  = 1'b1;
                end
            end
        end
    end

    assign bus.req_ready = grant;

    logic signed [RW-1:0] a_ext;
    logic signed [RW-1:0] b_ext;
    logic [OW-1:0]        res;

    assign a_ext = {{(RW-AW){s1_a_q[AW-1]}}, s1_a_q};
    assign b_ext = {{(RW-BW){1'b0}}, s1_b_q};

`ifdef ADDSUB_RR_SAT_EN
    logic signed [RW-1:0] full;
    logic                 res_sat;
    logic                 s2_sat_q;

    assign full = s1_sub_q ? (a_ext - b_ext) : (a_ext + b_ext);

    generate
        if (RW > OW) begin : g_clamp
            localparam logic signed [RW-1:0] SAT_MAX = {{(RW-OW+1){1'b0}}, {(OW-1){1'b1}}};
            localparam logic signed [RW-1:0] SAT_MIN = {{(RW-OW+1){1'b1}}, {(OW-1){1'b0}}};
            always_comb begin
                res     = full[OW-1:0];
                res_sat = 1'b0;
                if (full > SAT_MAX) begin
                    res     = {1'b0, {(OW-1){1'b1}}};
                    res_sat = 1'b1;
                end else if (full < SAT_MIN) begin
                    res     = {1'b1, {(OW-1){1'b0}}};
                    res_sat = 1'b1;
                end
            end
        end else begin : g_noclamp
            assign res     = OW'(full);
            assign res_sat = 1'b0;
        end
    endgenerate

    assign bus.rsp_sat = s2_sat_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            s2_sat_q <= 1'b0;
        end else if (adv2) begin
            s2_sat_q <= res_sat;
        end
    end
`else
    assign res         = OW'(s1_sub_q ? (a_ext - b_ext) : (a_ext + b_ext));
    assign bus.rsp_sat = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            rr_ptr_q   <= '0;
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_sub_q   <= 1'b0;
            s1_id_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_id_q    <= '0;
        end else begin
            if (grant_any) begin
                rr_ptr_q <= (grant_id == IDW'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
            end
            // Stage 1 only refills when its content moves on (or it was empty).
            if (adv1) begin
                s1_valid_q <= grant_any;
                s1_a_q     <= a_arr[grant_id];
                s1_b_q     <= b_arr[grant_id];
                s1_sub_q   <= bus.req_sub[grant_id];
                s1_id_q    <= grant_id;
            end
            if (adv2) begin
                s2_valid_q <= s1_valid_q;
                s2_data_q  <= res;
                s2_id_q    <= s1_id_q;
            end
        end
    end

    assign bus.rsp_valid = s2_valid_q;
    assign bus.rsp_data  = s2_data_q;
    assign bus.rsp_id    = s2_id_q;

endmodule

// File: tb/tb_addsub_rr_scheduler.sv
// Directed bench for addsub_rr_scheduler: vector table plus arbitration, stall and reset sequences.
// Expected results follow ADDSUB_RR_SAT_EN when it is defined.
module tb_addsub_rr_scheduler;
    localparam int NUM_REQ = 4;
    localparam int AW      = 4;
    localparam int BW      = 8;
    localparam int OW      = 9;
    localparam int IDW     = 2;

    logic clk = 1'b0;
    logic rst_b;
    always #5 clk = ~clk;

    addsub_rr_scheduler_if #(.NUM_REQ(NUM_REQ), .AW(AW), .BW(BW), .OW(OW), .IDW(IDW)) ifc ();

    addsub_rr_scheduler #(.NUM_REQ(NUM_REQ), .AW(AW), .BW(BW), .OW(OW), .IDW(IDW)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (ifc)
    );

    typedef struct {
        int id;
        int data;
        bit sat;
    } exp_t;

    typedef struct {
        int id;
        int a;
        int b;
        bit sub;
        int exp_data;
        bit exp_sat;
    } vec_t;

    exp_t sbq[$];
    exp_t mon_e;
    vec_t vecs[8];

    int checks = 0;
    int errors = 0;
    int accepts = 0;
    int a_v[NUM_REQ];
    int b_v[NUM_REQ];
    bit sub_v[NUM_REQ];

    logic [NUM_REQ-1:0] ready_s;
    logic               rsp_valid_s;
    int                 rsp_data_s;
    int                 rsp_id_s;
    int                 rsp_sat_s;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference result: exact integer arithmetic, then wrap or clamp to 9 bits.
    function automatic exp_t model(input int id, input int a, input int b, input bit sub);
        exp_t e;
        int full;
        int w;
        full  = sub ? (a - b) : (a + b);
        e.id  = id;
        e.sat = 1'b0;
`ifdef ADDSUB_RR_SAT_EN
        if (full > 255) begin
            e.data = 255;
            e.sat  = 1'b1;
        end else if (full < -256) begin
            e.data = -256;
            e.sat  = 1'b1;
        end else begin
            e.data = full;
        end
`else
        w = full & 511;
        if (w >= 256) w = w - 512;
        e.data = w;
`endif
        return e;
    endfunction

    task automatic drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            ifc.req_a[i*AW +: AW] = AW'(a_v[i]);
            ifc.req_b[i*BW +: BW] = BW'(b_v[i]);
            ifc.req_sub[i]        = sub_v[i];
        end
    endtask

    // One clock: sample at the falling edge, log accepts, return just after the rising edge.
    task automatic step();
        @(negedge clk);
        ready_s     = ifc.req_ready;
        rsp_valid_s = ifc.rsp_valid;
        rsp_data_s  = int'($signed(ifc.rsp_data));
        rsp_id_s    = int'(ifc.rsp_id);
        rsp_sat_s   = int'(ifc.rsp_sat);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ifc.req_valid[i] && ifc.req_ready[i]) begin
                sbq.push_back(model(i, a_v[i], b_v[i], sub_v[i]));
                accepts++;
                $display("REQ id=%0d a=%0d b=%0d sub=%0d", i, a_v[i], b_v[i], sub_v[i]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Response scoreboard plus hold-stability check while stalled.
    logic          prev_hold = 1'b0;
    logic [OW-1:0] prev_data;
    logic [IDW-1:0] prev_id;
    always @(negedge clk) begin
        if (!rst_b) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", int'(ifc.rsp_valid), 1);
                check("hold_data", int'(ifc.rsp_data), int'(prev_data));
                check("hold_id", int'(ifc.rsp_id), int'(prev_id));
            end
            if (ifc.rsp_valid && ifc.rsp_ready) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got id=%0d data=%0d expected no response",
                             ifc.rsp_id, $signed(ifc.rsp_data));
                end else begin
                    mon_e = sbq.pop_front();
                    check("rsp_id", int'(ifc.rsp_id), mon_e.id);
                    check("rsp_data", int'($signed(ifc.rsp_data)), mon_e.data);
                    check("rsp_sat", int'(ifc.rsp_sat), int'(mon_e.sat));
                    $display("RSP id=%0d data=%0d sat=%0d", ifc.rsp_id, $signed(ifc.rsp_data), ifc.rsp_sat);
                end
            end
            prev_hold = ifc.rsp_valid && !ifc.rsp_ready;
            prev_data = ifc.rsp_data;
            prev_id   = ifc.rsp_id;
        end
    end

    initial begin
        vecs[0] = '{0,  6,  20, 1'b1, -14, 1'b0};
`ifdef ADDSUB_RR_SAT_EN
        vecs[1] = '{2, -8, 255, 1'b1, -256, 1'b1};
        vecs[2] = '{1,  7, 255, 1'b0,  255, 1'b1};
        vecs[6] = '{2,  1, 255, 1'b0,  255, 1'b1};
`else
        vecs[1] = '{2, -8, 255, 1'b1,  249, 1'b0};
        vecs[2] = '{1,  7, 255, 1'b0, -250, 1'b0};
        vecs[6] = '{2,  1, 255, 1'b0, -256, 1'b0};
`endif
        vecs[3] = '{0, -8,   0, 1'b1,   -8, 1'b0};
        vecs[4] = '{1,  5, 100, 1'b0,  105, 1'b0};
        vecs[5] = '{3,  0, 255, 1'b1, -255, 1'b0};
        vecs[7] = '{3, -1,   0, 1'b0,   -1, 1'b0};

        // Reset state, with every requester asking.
        rst_b = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            a_v[i] = 0; b_v[i] = 0; sub_v[i] = 1'b0;
        end
        drive();
        ifc.req_valid = '1;
        ifc.rsp_ready = 1'b1;
        @(negedge clk);
        check("rst_req_ready", int'(ifc.req_ready), 0);
        check("rst_rsp_valid", int'(ifc.rsp_valid), 0);
        check("rst_rsp_data", int'(ifc.rsp_data), 0);
        check("rst_rsp_id", int'(ifc.rsp_id), 0);
        check("rst_rsp_sat", int'(ifc.rsp_sat), 0);
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        ifc.req_valid = '0;

        // Single requests from the table: grant, 2-cycle latency, value.
        for (int v = 0; v < 8; v++) begin
            a_v[vecs[v].id]   = vecs[v].a;
            b_v[vecs[v].id]   = vecs[v].b;
            sub_v[vecs[v].id] = vecs[v].sub;
            drive();
            ifc.req_valid = NUM_REQ'(1 << vecs[v].id);
            step();
            check("vec_grant", int'(ready_s), 1 << vecs[v].id);
            check("vec_lat0", int'(rsp_valid_s), 0);
            ifc.req_valid = '0;
            step();
            check("vec_lat1", int'(rsp_valid_s), 0);
            step();
            check("vec_valid", int'(rsp_valid_s), 1);
            check("vec_data", rsp_data_s, vecs[v].exp_data);
            check("vec_id", rsp_id_s, vecs[v].id);
            check("vec_sat", rsp_sat_s, int'(vecs[v].exp_sat));
            step();
            check("vec_done", int'(rsp_valid_s), 0);
        end

        // All requesters busy: grants rotate 0,1,2,3 and results stream back-to-back.
        for (int i = 0; i < NUM_REQ; i++) begin
            a_v[i] = 1; b_v[i] = i; sub_v[i] = 1'b0;
        end
        drive();
        ifc.req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            step();
            check("rr_grant", int'(ready_s), 1 << (k % 4));
            if (k >= 2) begin
                check("rr_rsp_valid", int'(rsp_valid_s), 1);
                check("rr_rsp_id", rsp_id_s, (k - 2) % 4);
            end
        end
        ifc.req_valid = '0;
        repeat (3) step();
        check("rr_drain", sbq.size(), 0);

        // Six stalled cycles: two results held, no further grants, then in-order release.
        accepts = 0;
        ifc.req_valid = '1;
        ifc.rsp_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (k >= 2) begin
                check("stall_ready", int'(ready_s), 0);
                check("stall_valid", int'(rsp_valid_s), 1);
                check("stall_id", rsp_id_s, 0);
            end
        end
        check("stall_held", accepts, 2);
        ifc.rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("release_valid", int'(rsp_valid_s), 1);
            check("release_id", rsp_id_s, k);
        end
        ifc.req_valid = '0;
        repeat (3) step();
        check("release_drain", sbq.size(), 0);

        // rr_ptr is 2 here: req3 wins over req1, and the pointer returns to 2.
        a_v[1] = 3;  b_v[1] = 4;  sub_v[1] = 1'b1;
        a_v[3] = -2; b_v[3] = 10; sub_v[3] = 1'b0;
        drive();
        ifc.req_valid = 4'b1010;
        step();
        check("rr5_first", int'(ready_s), 4'b1000);
        ifc.req_valid[3] = 1'b0;
        step();
        check("rr5_second", int'(ready_s), 4'b0010);
        ifc.req_valid = '0;
        repeat (2) step();
        ifc.req_valid = '1;
        step();
        check("rr5_ptr", int'(ready_s), 4'b0100);
        ifc.req_valid = '0;
        repeat (3) step();
        check("rr5_drain", sbq.size(), 0);

        // Reset with both stages full drops everything in flight.
        ifc.rsp_ready = 1'b0;
        ifc.req_valid = '1;
        repeat (2) step();
        rst_b = 1'b0;
        #1;
        check("midrst_rsp_valid", int'(ifc.rsp_valid), 0);
        check("midrst_req_ready", int'(ifc.req_ready), 0);
        check("midrst_rsp_data", int'(ifc.rsp_data), 0);
        sbq.delete();
        ifc.req_valid = '0;
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        ifc.rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("midrst_quiet", int'(rsp_valid_s), 0);
        end
        a_v[1] = 5; b_v[1] = 3; sub_v[1] = 1'b0;
        drive();
        ifc.req_valid = 4'b0010;
        step();
        check("midrst_grant", int'(ready_s), 4'b0010);
        ifc.req_valid = '0;
        step();
        check("midrst_lat1", int'(rsp_valid_s), 0);
        step();
        check("midrst_valid", int'(rsp_valid_s), 1);
        check("midrst_data", rsp_data_s, 8);
        check("midrst_id", rsp_id_s, 1);
        step();
        check("final_drain", sbq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
